// File: rtl/bus_bridge_pkg.sv
// rtl/bus_bridge_pkg.sv - shared types and constants for the FemtoRV32 bus bridge
package bus_bridge_pkg;

    typedef enum logic [1:0] {
        BRIdle,
        BRRequest,
        BRRelease
    } BridgeState;

    typedef enum logic {
        OpRead,
        OpWrite
    } BridgeOp;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_timeout.sv
// rtl/bus_timeout.sv - per-phase handshake watchdog counter
//
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   clear       : restart the count (issued on every bridge state change)
//   enable      : count this cycle (bridge is inside a handshake phase)
//   expire      : phase has lasted TIMEOUT_CYCLES cycles including this one
module bus_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            // The count never passes TIMEOUT_CYCLES-1: expiry forces a state
            // change, which clears it.
            localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (enable) begin
                    count <= count + 1'b1;
                end
            end

            assign expire = enable && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/sdram_bus_bridge.sv
// rtl/sdram_bus_bridge.sv - FemtoRV32 memory bus to single valid/ready slave bridge
//
// Ports:
//   clk, resetn           : clock, asynchronous active-low reset
//   cpu_addr/wdata/wmask  : CPU request; nonzero wmask is a write
//   cpu_rstrb             : one-cycle read strobe
//   cpu_rdata             : captured read data (ERR_DATA after a read timeout)
//   cpu_rbusy/cpu_wbusy   : CPU stalls, already high in the strobe cycle
//   sel                   : combinational region hit
//   slv_addr/din/wmask    : request latched at start (wmask 0 = read)
//   slv_valid/slv_ready   : four-phase handshake to the slave
//   slv_dout              : slave read data
//   err/err_clr           : sticky timeout flag and its clear
module sdram_bus_bridge
    import bus_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
    parameter logic [31:0] REGION_MASK    = 32'hF000_0000,
    parameter int          SLV_ADDR_WIDTH = 25,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [31:0]               cpu_addr,
    input  logic [31:0]               cpu_wdata,
    input  logic [3:0]                cpu_wmask,
    input  logic                      cpu_rstrb,
    output logic [31:0]               cpu_rdata,
    output logic                      cpu_rbusy,
    output logic                      cpu_wbusy,
    output logic                      sel,
    output logic [SLV_ADDR_WIDTH-1:0] slv_addr,
    output logic [31:0]               slv_din,
    output logic [3:0]                slv_wmask,
    output logic                      slv_valid,
    input  logic                      slv_ready,
    input  logic [31:0]               slv_dout,
    output logic                      err,
    input  logic                      err_clr
);

    BridgeState state, state_next;
    BridgeOp    op;

    logic                      write_req;
    logic                      start;
    logic                      exit_cond;
    logic                      expire;
    logic                      timeout;
    logic [SLV_ADDR_WIDTH-3:0] word_addr;

    assign sel       = (cpu_addr & REGION_MASK) == BASE_ADDR;
    assign write_req = |cpu_wmask;
    assign start     = (state == BRIdle) && sel && (cpu_rstrb || write_req);
    assign word_addr = cpu_addr[SLV_ADDR_WIDTH-1:2] & ~REGION_MASK[SLV_ADDR_WIDTH-1:2];

    // Valid is a pure decode of the state so an asynchronous reset drops it
    // in the same instant, and a timeout drops it with the return to idle.
    assign slv_valid = (state == BRRequest);

    // The strobe-cycle term lets the CPU stall before the request registers.
    assign cpu_rbusy = (start && !write_req) || (state != BRIdle && op == OpRead);
    assign cpu_wbusy = (start &&  write_req) || (state != BRIdle && op == OpWrite);

    assign timeout = expire && !exit_cond;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= BRIdle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        exit_cond  = 1'b0;
        unique case (state)
            BRIdle: begin
                if (start) begin
                    state_next = BRRequest;
                end
            end
            BRRequest: begin
                exit_cond = slv_ready;
                if (slv_ready) begin
                    state_next = BRRelease;
                end else if (timeout) begin
                    state_next = BRIdle;
                end
            end
            BRRelease: begin
                exit_cond = !slv_ready;
                if (!slv_ready || timeout) begin
                    state_next = BRIdle;
                end
            end
            default: begin
                state_next = BRIdle;
            end
        endcase
    end

    bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .resetn (resetn),
        .clear  (state_next != state),
        .enable (state != BRIdle),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op        <= OpRead;
            slv_addr  <= '0;
            slv_din   <= '0;
            slv_wmask <= '0;
            cpu_rdata <= '0;
            err       <= 1'b0;
        end else begin
            if (start) begin
                slv_addr  <= {word_addr, 2'b00};
                slv_din   <= cpu_wdata;
                slv_wmask <= cpu_wmask;
                op        <= write_req ? OpWrite : OpRead;
            end

            if (state == BRRequest && slv_ready && op == OpRead) begin
                cpu_rdata <= slv_dout;
            end else if (timeout && op == OpRead) begin
                cpu_rdata <= ERR_DATA;
            end

            // Leaving a transaction by either route returns wmask to "read".
            if (state != BRIdle && state_next == BRIdle) begin
                slv_wmask <= '0;
            end

            if (timeout) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_bus_bridge.sv
// tb/tb_sdram_bus_bridge.sv - self-checking bench for sdram_bus_bridge
module tb_sdram_bus_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, slv_din, slv_dout;
    logic [3:0]  cpu_wmask, slv_wmask;
    logic        cpu_rstrb, cpu_rbusy, cpu_wbusy, sel;
    logic [24:0] slv_addr;
    logic        slv_valid, slv_ready, err, err_clr;

    int n_checks = 0;
    int n_fail   = 0;
    int last_busy;
    logic [31:0] exp_rdata;
    logic        exp_err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        rstrb;
        int          dreq;
        int          drel;
        logic [31:0] dout;
        int          clr_at;
        bit          b2b;
        bit          exp_sel;
        int          exp_busy;
    } vec_t;

    vec_t vecs[9];

    sdram_bus_bridge #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wmask (cpu_wmask),
        .cpu_rstrb (cpu_rstrb),
        .cpu_rdata (cpu_rdata),
        .cpu_rbusy (cpu_rbusy),
        .cpu_wbusy (cpu_wbusy),
        .sel       (sel),
        .slv_addr  (slv_addr),
        .slv_din   (slv_din),
        .slv_wmask (slv_wmask),
        .slv_valid (slv_valid),
        .slv_ready (slv_ready),
        .slv_dout  (slv_dout),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One CPU transaction with a slave that raises ready after dreq valid
    // cycles and drops it after drel release cycles. Returns in the first
    // idle cycle (negedge + 1) so the next call may strobe back-to-back.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm,
                          input logic rs, input int dreq, input int drel, input logic [31:0] dout,
                          input int clr_at, input bit b2b);
        bit hit, is_wr, to, other, done;
        int busy_n, valid_n, rel_n, exp_busy, exp_valid;
        hit   = (a[31:28] == 4'h4);
        is_wr = (wm != 4'h0);
        if (!b2b) @(negedge clk);
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_wmask = wm;
        cpu_rstrb = rs;
        slv_ready = 1'b0;
        slv_dout  = dout;
        #1;
        check("sel", sel, hit);
        check("rbusy_strobe", cpu_rbusy, hit && !is_wr);
        check("wbusy_strobe", cpu_wbusy, hit && is_wr);
        busy_n  = (cpu_rbusy || cpu_wbusy) ? 1 : 0;
        valid_n = 0;
        rel_n   = 0;
        other   = 0;
        done    = 0;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            cpu_wmask = 4'h0;
            cpu_rstrb = 1'b0;
            err_clr   = 1'b0;
            #1;
            if (!(cpu_rbusy || cpu_wbusy)) begin
                done = 1;
                break;
            end
            busy_n++;
            if (is_wr ? cpu_rbusy : cpu_wbusy) other = 1;
            if (slv_valid) begin
                valid_n++;
                if (valid_n == 1) check("slv_wmask", {28'h0, slv_wmask}, {28'h0, wm});
                if (valid_n == clr_at) err_clr = 1'b1;
                slv_ready = (valid_n > dreq);
            end else begin
                rel_n++;
                slv_ready = (rel_n <= drel);
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL txn_timeout: busy never dropped, addr %h", a);
        end
        to        = hit && (dreq + 1 > TMO);
        exp_valid = !hit ? 0 : (to ? TMO : dreq + 1);
        exp_busy  = !hit ? 0 : 1 + exp_valid + (to ? 0 : drel + 1);
        last_busy = busy_n;
        check("busy_cycles", busy_n, exp_busy);
        check("valid_cycles", valid_n, exp_valid);
        check("other_busy", {31'h0, other}, 32'h0);
        check("valid_idle", {31'h0, slv_valid}, 32'h0);
        if (hit) begin
            check("slv_addr", {7'h0, slv_addr}, a & 32'h01FF_FFFC);
            check("slv_din", slv_din, wd);
            if (!is_wr) exp_rdata = to ? 32'hDEAD_BEEF : dout;
            if (to) exp_err = 1'b1;
            else if (clr_at > 0 && clr_at <= valid_n) exp_err = 1'b0;
        end
        check("cpu_rdata", cpu_rdata, exp_rdata);
        check("err", {31'h0, err}, {31'h0, exp_err});
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        exp_err = 1'b0;
        check("err_clr_idle", {31'h0, err}, 32'h0);
    endtask

    initial begin
        //             addr           wdata          wmask rs dreq drel dout          clr b2b sel busy
        vecs[0] = '{32'h4000_0104, 32'h0000_0000, 4'h0, 1, 2,  0, 32'h1234_5678, 0, 0, 1, 5};
        vecs[1] = '{32'h4000_0008, 32'hCAFE_0000, 4'h3, 0, 0,  0, 32'h0BAD_0BAD, 0, 0, 1, 3};
        vecs[2] = '{32'h0000_0010, 32'h0000_0000, 4'h0, 1, 0,  0, 32'h0000_0001, 0, 0, 0, 0};
        vecs[3] = '{32'h4000_0020, 32'h1111_2222, 4'hF, 1, 1,  1, 32'h0000_0002, 0, 0, 1, 5};
        vecs[4] = '{32'h4000_0040, 32'h3333_4444, 4'h8, 0, 0,  2, 32'h0000_0003, 0, 0, 1, 5};
        vecs[5] = '{32'h4000_0044, 32'h0000_0000, 4'h0, 1, 0,  0, 32'hA5A5_5A5A, 0, 1, 1, 3};
        vecs[6] = '{32'h4000_0400, 32'h0000_0000, 4'h0, 1, 7,  0, 32'h7777_0007, 0, 0, 1, 10};
        vecs[7] = '{32'h4000_0200, 32'h0000_0000, 4'h0, 1, 99, 0, 32'h5555_5555, 0, 0, 1, 9};
        vecs[8] = '{32'h4000_0204, 32'h0000_0000, 4'h0, 1, 99, 0, 32'h6666_6666, 8, 0, 1, 9};

        resetn    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_wmask = '0;
        cpu_rstrb = 1'b0;
        slv_ready = 1'b0;
        slv_dout  = '0;
        err_clr   = 1'b0;
        exp_rdata = '0;
        exp_err   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {31'h0, slv_valid}, 32'h0);
        check("rst_wmask", {28'h0, slv_wmask}, 32'h0);
        check("rst_addr", {7'h0, slv_addr}, 32'h0);
        check("rst_din", slv_din, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_busy", {30'h0, cpu_rbusy, cpu_wbusy}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            do_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wmask, vecs[i].rstrb, vecs[i].dreq,
                   vecs[i].drel, vecs[i].dout, vecs[i].clr_at, vecs[i].b2b);
            check("tbl_busy", last_busy, vecs[i].exp_busy);
        end

        // Reset while a request is outstanding: valid must fall immediately.
        @(negedge clk);
        cpu_addr  = 32'h4000_0300;
        cpu_rstrb = 1'b1;
        @(negedge clk);
        cpu_rstrb = 1'b0;
        @(negedge clk);
        #1;
        check("midop_valid_before", {31'h0, slv_valid}, 32'h1);
        resetn = 1'b0;
        #1;
        check("midop_valid", {31'h0, slv_valid}, 32'h0);
        check("midop_busy", {30'h0, cpu_rbusy, cpu_wbusy}, 32'h0);
        check("midop_err", {31'h0, err}, 32'h0);
        check("midop_rdata", cpu_rdata, 32'h0);
        exp_rdata = '0;
        exp_err   = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        do_txn(32'h4000_0500, 32'h0, 4'h0, 1'b1, 99, 0, 32'h0, 0, 0);
        pulse_clr();

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, wd, dout;
            logic [3:0]  wm;
            logic        rs;
            int          dreq, drel;
            if ($urandom_range(0, 3) != 0) a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
            else                           a = $urandom & 32'h3FFF_FFFF;
            wd   = $urandom;
            dout = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                wm = 4'($urandom_range(1, 15));
                rs = 1'($urandom_range(0, 1));
            end else begin
                wm = 4'h0;
                rs = 1'b1;
            end
            dreq = $urandom_range(0, 9);
            drel = $urandom_range(0, 3);
            do_txn(a, wd, wm, rs, dreq, drel, dout, 0, bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) pulse_clr();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_bus_bridge.md
Name: sdram_bus_bridge

Overview:
Parametrised bridge between the FemtoRV32 memory bus (rstrb/wmask strobes, rbusy/wbusy stalls) and a single valid/ready slave such as the sdram controller. It decodes one address region, latches each request, and runs the full four-phase valid/ready handshake. It generates the CPU busy flags, captures read data, and aborts hung transactions with a timeout and a sticky error flag. Multiple instances with different BASE_ADDR/REGION_MASK values sit side by side in the SoC; their busy/rdata outputs are ORed upstream.

Parameters:
BASE_ADDR, 32'h4000_0000, region base; hit when (cpu_addr & REGION_MASK) == BASE_ADDR
REGION_MASK, 32'hF000_0000, address bits that select the region
SLV_ADDR_WIDTH, 25, slave address width (byte address, word aligned)
TIMEOUT_CYCLES, 1024, max cycles per handshake phase; 0 disables the timeout
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous, active-low reset
cpu_addr  in  32  CPU byte address
cpu_wdata  in  32  CPU write data
cpu_wmask  in  4  write byte strobes; nonzero means write
cpu_rstrb  in  1  read strobe, one-cycle pulse
cpu_rdata  out  32  read data to the CPU
cpu_rbusy  out  1  read stall
cpu_wbusy  out  1  write stall
sel  out  1  combinational region hit
slv_addr  out  SLV_ADDR_WIDTH  latched slave address
slv_din  out  32  latched write data
slv_wmask  out  4  latched strobes; 0 means read
slv_valid  out  1  request valid
slv_ready  in  1  slave ready/ack
slv_dout  in  32  slave read data
err  out  1  sticky timeout flag
err_clr  in  1  clears err

Behaviour:
- Reset (async, resetn=0): state=BRIdle, slv_valid=0, slv_wmask=0, slv_addr=0, slv_din=0, cpu_rdata=0, err=0, timer=0. slv_valid drops in the same instant as reset, even mid-transaction.
- sel = region hit (combinational). start = BRIdle & sel & (cpu_rstrb | |cpu_wmask).
- On start: latch slv_addr = {(cpu_addr & ~REGION_MASK)[SLV_ADDR_WIDTH-1:2], 2'b00}, slv_din = cpu_wdata, slv_wmask = cpu_wmask, and op = write if |cpu_wmask, else read. If both strobes are present, write wins. Next state is BRRequest.
- cpu_rbusy = (start & read) | (state != BRIdle & op == read). cpu_wbusy is the same with op == write. Busy is therefore high in the strobe cycle itself and is 0 whenever sel=0.
- BRRequest: slv_valid=1. On slv_ready=1: capture cpu_rdata = slv_dout (reads only), set slv_valid=0, go to BRRelease.
- BRRelease: slv_valid=0. On slv_ready=0: go to BRIdle and clear slv_wmask. Busy falls in the first BRIdle cycle.
- Best-case latency: strobe cycle, then BRRequest with ready already high, then BRRelease with ready low. Busy stays high for 3 cycles.
- cpu_rdata holds its value until the next read capture. Writes do not change it.
- Timer: cleared on every state change and incremented in BRRequest and BRRelease. When the timer reaches TIMEOUT_CYCLES-1 without the exit condition:
  - set err=1;
  - on a read, load cpu_rdata = ERR_DATA;
  - force slv_valid=0 and go to BRIdle.
- err_clr clears err. If err_clr and a timeout set occur in the same cycle, the set wins.
- Strobes arriving while state != BRIdle are ignored (the CPU is stalled). Strobes with sel=0 are ignored entirely.
- A new start is allowed in the first BRIdle cycle after completion (back-to-back).

Decomposition:
- Package bus_bridge_pkg:
  - typedef enum BridgeState {BRIdle, BRRequest, BRRelease};
  - typedef enum BridgeOp {OpRead, OpWrite};
  - default ERR_DATA constant.
- Sub-module bus_timeout: counter with clear/enable/expire, parametrised by TIMEOUT_CYCLES, same clk/resetn. Expire is tied to 0 when TIMEOUT_CYCLES=0.

Test Plan:
- Read hit: cpu_addr=32'h4000_0104, rstrb pulse; slave raises ready 2 cycles after valid with dout=32'h1234_5678 -> slv_addr=25'h104, rbusy high from the strobe cycle until BRIdle, cpu_rdata=32'h1234_5678, wbusy stays 0.
- Write hit: cpu_addr=32'h4000_0008, wmask=4'b0011, wdata=32'hCAFE_0000 -> slv_wmask=4'b0011, slv_din latched, wbusy high, cpu_rdata unchanged.
- Miss: cpu_addr=32'h0000_0010, rstrb -> sel=0, no slv_valid, both busy flags 0.
- Timeout: TIMEOUT_CYCLES=8, read with ready never asserted -> valid drops after 8 BRRequest cycles, err=1, cpu_rdata=32'hDEAD_BEEF. Then err_clr coinciding with a second timeout -> err stays 1.
- Reset mid-op: assert resetn=0 during BRRequest -> slv_valid=0 immediately, state BRIdle, busy 0, err 0.
- Back-to-back: a write then a read strobed in the first idle cycle -> both complete, slv_addr updates, no lost request.
